smartlock_param: RTL
====================

Name: smartlock_param

Overview:
- Parametrised keypad lock controller, the successor to the fixed 4-digit lock FSM.
- Takes ten raw digit buttons and a clear button, and edge-detects each.
- Collects a CODE_LEN-digit entry and compares the whole entry against a stored code, so the failing digit is never revealed.
- Counts failed attempts with a timed lockout; the code can be reprogrammed while open.

Parameters:
- CODE_LEN, 4, digits per code (1..8).
- DEFAULT_CODE, 32'h0000_2479, reset code as BCD nibbles; the low CODE_LEN nibbles are used and the most significant used nibble is the first digit.
- MAX_TRIES, 3, consecutive failed entries that trigger lockout (>=1).
- LOCKOUT_CYCLES, 1000, clock cycles spent in lockout (>=1).
- RELOCK_CYCLES, 5000, open-state timeout; used only with AUTO_RELOCK_EN.

Ports:
- clk, input, 1, system clock.
- reset, input, 1, asynchronous active-high reset.
- key_in, input, 10, raw digit buttons; bit i is digit i.
- clear_in, input, 1, raw clear/relock button.
- prog_in, input, 1, raw program-code button.
- out, output, 1, lock open (high in S_OPEN only).
- locked_out, output, 1, high in S_LOCKOUT.
- prog_mode, output, 1, high in S_PROG.
- digit_cnt, output, 4, digits accepted in the current entry.
- fail_cnt, output, 4, consecutive failed entries.

Behaviour:
- Reset (async): state S_ENTRY; stored code = DEFAULT_CODE; all outputs, counters and timers 0; mismatch flag cleared.
- Edge detect, per raw input: 3-flop shift (r1, r2, r3); pulse = r2 & ~r3.
  - The pulse lasts exactly one cycle and is high in the cycle after the 2nd rising clk edge that samples the input high.
  - Holding a button produces one pulse only.
- Digit event: exactly one key pulse in a cycle. Two or more key pulses in the same cycle are one "invalid digit", which counts as a mismatching digit.
- S_ENTRY:
  - Each digit event: compare against code nibble[digit_cnt]; set the mismatch flag on a miss; increment digit_cnt.
  - On the event that makes digit_cnt == CODE_LEN:
    - No mismatch: go to S_OPEN; fail_cnt <= 0.
    - Mismatch and fail_cnt+1 == MAX_TRIES: go to S_LOCKOUT; load the timer with LOCKOUT_CYCLES-1; fail_cnt <= MAX_TRIES.
    - Otherwise: fail_cnt += 1 and stay in S_ENTRY.
    - In every case: digit_cnt <= 0 and the mismatch flag is cleared.
  - clear pulse: abort the partial entry (digit_cnt 0, flag cleared); fail_cnt unchanged.
  - prog pulse: ignored.
- S_OPEN:
  - clear pulse: go to S_ENTRY.
  - prog pulse: go to S_PROG, digit_cnt 0.
  - Digit pulses are ignored.
- S_PROG:
  - Each digit event writes nibble[digit_cnt] into a shadow register.
  - After CODE_LEN digits: commit the shadow to the stored code atomically and go to S_OPEN.
  - An invalid digit aborts to S_OPEN with no commit.
  - clear pulse: abort to S_OPEN, stored code unchanged.
- S_LOCKOUT:
  - All buttons are ignored, including clear.
  - The timer decrements each cycle. At 0 go to S_ENTRY with fail_cnt <= 0. Lockout therefore lasts exactly LOCKOUT_CYCLES cycles.
- Priority within one cycle: clear pulse > prog pulse > digit event.
- Outputs are registered state decodes. out rises on the clock edge after the final digit pulse cycle.
- Internal count widths are sized by $clog2 of their limits. digit_cnt and fail_cnt are zero-extended to 4 bits.

Optional Feature:
- Macro: SMARTLOCK_AUTO_RELOCK_EN.
- Defined: entering S_OPEN loads a relock timer with RELOCK_CYCLES-1. The timer decrements in S_OPEN and S_PROG. At 0 the block goes to S_ENTRY, discarding any in-progress program shadow. Any digit pulse in S_PROG reloads the timer.
- Undefined: S_OPEN persists until clear; no timer logic is generated.

Decomposition:
- Package smartlock_pkg:
  - state encoding S_ENTRY=3'd0, S_OPEN=3'd1, S_PROG=3'd2, S_LOCKOUT=3'd3;
  - NUM_KEYS=10;
  - DIGIT_W=4.
- Sub-module button_edge (clk, reset, in, pulse): 3-flop edge detector with async reset, instantiated 12 times via generate.
- Keep the FSM, counters and code storage in smartlock_param.

Test Plan:
- Default code: reset, then press 2,4,7,9 (each high 2 cycles, low 2 cycles) -> out=1 one cycle after the 9 pulse; fail_cnt=0.
- Wrong digit: press 2,1,7,9 -> out stays 0, fail_cnt=1, digit_cnt=0. Then 2,4,7,9 -> out=1, fail_cnt=0.
- Lockout: three wrong 4-digit entries -> locked_out=1 for exactly 1000 cycles. Presses of 2,4,7,9 and clear during lockout have no effect. Afterwards S_ENTRY with fail_cnt=0.
- Reprogram: open, prog, press 1,3,5,8 -> prog_mode 1 then 0. Clear, then enter 2,4,7,9 -> fail_cnt=1. Enter 1,3,5,8 -> out=1.
- Edge cases:
  - Keys 3 and 5 pulse in the same cycle -> counted as one mismatching digit.
  - clear after 2 digits -> digit_cnt=0, fail_cnt unchanged.
  - Held key -> one digit only.
- Async reset mid-entry and mid-lockout -> all outputs 0 immediately; code returns to 2479 even after reprogramming. With SMARTLOCK_AUTO_RELOCK_EN, out falls after 5000 cycles.

Source files
------------

// File: rtl/smartlock_pkg.sv
// Shared definitions for the parametrised keypad lock: state encoding,
// keypad geometry and a one-hot-to-digit helper.
package smartlock_pkg;

   typedef enum logic [2:0] {
      S_ENTRY   = 3'd0,
      S_OPEN    = 3'd1,
      S_PROG    = 3'd2,
      S_LOCKOUT = 3'd3
   } state_t;

   localparam int NUM_KEYS = 10;
   localparam int DIGIT_W  = 4;

   // Index of the lowest set key; only meaningful when exactly one is set.
   function automatic logic [DIGIT_W-1:0] key_encode(input logic [NUM_KEYS-1:0] keys);
      logic [DIGIT_W-1:0] idx;
      idx = '0;
      for (int i = NUM_KEYS - 1; i >= 0; i--) begin
         if (keys[i]) idx = DIGIT_W'(i);
      end
      return idx;
   endfunction

endpackage

// File: rtl/smartlock_param_button_edge.sv
// Button edge detector: three-flop shift of the raw input, one-cycle pulse
// on the registered rising edge. A held button yields a single pulse.
module button_edge (
   input  logic clk,
   input  logic reset,
   input  logic in,
   output logic pulse
);

   logic r1, r2, r3;

   // Synchronise the raw button and keep one extra stage for edge detection
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         r1 <= 1'b0;
         r2 <= 1'b0;
         r3 <= 1'b0;
      end else begin
         r1 <= in;
         r2 <= r1;
         r3 <= r2;
      end
   end

   assign pulse = r2 & ~r3;

endmodule

// File: rtl/smartlock_param.sv
// Parametrised keypad lock controller. Collects CODE_LEN digits, compares
// the whole entry against the stored code, locks out after MAX_TRIES
// failures and allows reprogramming while open.
// Optional feature macro: SMARTLOCK_AUTO_RELOCK_EN (open/program timeout).
module smartlock_param
   import smartlock_pkg::*;
#(
   parameter int          CODE_LEN       = 4,
   parameter logic [31:0] DEFAULT_CODE   = 32'h0000_2479,
   parameter int          MAX_TRIES      = 3,
   parameter int          LOCKOUT_CYCLES = 1000,
   parameter int          RELOCK_CYCLES  = 5000
) (
   input  logic                clk,
   input  logic                reset,
   input  logic [NUM_KEYS-1:0] key_in,
   input  logic                clear_in,
   input  logic                prog_in,
   output logic                out,
   output logic                locked_out,
   output logic                prog_mode,
   output logic [3:0]          digit_cnt,
   output logic [3:0]          fail_cnt
);

   localparam int CODE_W = CODE_LEN * DIGIT_W;
   localparam int DCNT_W = $clog2(CODE_LEN + 1);
   localparam int FCNT_W = $clog2(MAX_TRIES + 1);
   localparam int LT_W   = (LOCKOUT_CYCLES > 1) ? $clog2(LOCKOUT_CYCLES) : 1;

   localparam logic [DCNT_W-1:0] LAST_DIGIT = DCNT_W'(CODE_LEN - 1);
   localparam logic [FCNT_W-1:0] FAIL_LAST  = FCNT_W'(MAX_TRIES - 1);
   localparam logic [FCNT_W-1:0] FAIL_MAX   = FCNT_W'(MAX_TRIES);
   localparam logic [LT_W-1:0]   LOCK_LOAD  = LT_W'(LOCKOUT_CYCLES - 1);

   // Nibble at a given position of a packed code (position 0 = least significant)
   function automatic logic [DIGIT_W-1:0] nibble_at(input logic [CODE_W-1:0] word, input int pos);
      logic [CODE_W-1:0] sh;
      sh = word >> (DIGIT_W * pos);
      return sh[DIGIT_W-1:0];
   endfunction

   logic [NUM_KEYS+1:0] raw_vec, pulse_vec;
   logic [NUM_KEYS-1:0] key_p;
   logic                clear_p, prog_p;

   assign raw_vec = {prog_in, clear_in, key_in};

   for (genvar g = 0; g < NUM_KEYS + 2; g++) begin : g_btn
      button_edge u_btn (
         .clk   (clk),
         .reset (reset),
         .in    (raw_vec[g]),
         .pulse (pulse_vec[g])
      );
   end

   assign key_p   = pulse_vec[NUM_KEYS-1:0];
   assign clear_p = pulse_vec[NUM_KEYS];
   assign prog_p  = pulse_vec[NUM_KEYS+1];

   state_t              state;
   logic [CODE_W-1:0]   code_r, shadow_r, shadow_nx;
   logic [DCNT_W-1:0]   digit_cnt_r;
   logic [FCNT_W-1:0]   fail_cnt_r;
   logic                mismatch_r;
   logic [LT_W-1:0]     lock_tmr;
   logic                digit_evt, digit_ok, digit_miss, last_digit, relock_expired;
   logic [DIGIT_W-1:0]  digit_val;
   int                  code_pos;

`ifdef SMARTLOCK_AUTO_RELOCK_EN
   localparam int RT_W = (RELOCK_CYCLES > 1) ? $clog2(RELOCK_CYCLES) : 1;
   localparam logic [RT_W-1:0] RELOCK_LOAD = RT_W'(RELOCK_CYCLES - 1);
   logic [RT_W-1:0] relock_tmr;
   assign relock_expired = (relock_tmr == '0);
`else
   assign relock_expired = 1'b0;
`endif

   // The first digit entered lives in the most significant used nibble
   assign digit_evt  = |key_p;
   assign digit_ok   = $onehot(key_p);
   assign digit_val  = key_encode(key_p);
   assign code_pos   = CODE_LEN - 1 - int'(digit_cnt_r);
   assign digit_miss = !digit_ok || (digit_val != nibble_at(code_r, code_pos));
   assign last_digit = (digit_cnt_r == LAST_DIGIT);

   // Shadow code with the current digit merged in at its position
   always_comb begin
      shadow_nx = (shadow_r & ~(CODE_W'(4'hF) << (DIGIT_W * code_pos)))
                | (CODE_W'(digit_val) << (DIGIT_W * code_pos));
   end

   // Lock FSM with counters, timers, code storage and registered state decodes
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state       <= S_ENTRY;
         code_r      <= DEFAULT_CODE[CODE_W-1:0];
         shadow_r    <= '0;
         digit_cnt_r <= '0;
         fail_cnt_r  <= '0;
         mismatch_r  <= 1'b0;
         lock_tmr    <= '0;
         out         <= 1'b0;
         locked_out  <= 1'b0;
         prog_mode   <= 1'b0;
`ifdef SMARTLOCK_AUTO_RELOCK_EN
         relock_tmr  <= '0;
`endif
      end else begin
         case (state)
            S_ENTRY: begin
               if (clear_p) begin
                  digit_cnt_r <= '0;
                  mismatch_r  <= 1'b0;
               end else if (digit_evt) begin
                  if (last_digit) begin
                     digit_cnt_r <= '0;
                     mismatch_r  <= 1'b0;
                     if (!(mismatch_r || digit_miss)) begin
                        state      <= S_OPEN;
                        out        <= 1'b1;
                        fail_cnt_r <= '0;
`ifdef SMARTLOCK_AUTO_RELOCK_EN
                        relock_tmr <= RELOCK_LOAD;
`endif
                     end else if (fail_cnt_r == FAIL_LAST) begin
                        state      <= S_LOCKOUT;
                        locked_out <= 1'b1;
                        lock_tmr   <= LOCK_LOAD;
                        fail_cnt_r <= FAIL_MAX;
                     end else begin
                        fail_cnt_r <= fail_cnt_r + 1'b1;
                     end
                  end else begin
                     digit_cnt_r <= digit_cnt_r + 1'b1;
                     mismatch_r  <= mismatch_r | digit_miss;
                  end
               end
            end
            S_OPEN: begin
               if (clear_p || relock_expired) begin
                  state <= S_ENTRY;
                  out   <= 1'b0;
               end else if (prog_p) begin
                  state       <= S_PROG;
                  out         <= 1'b0;
                  prog_mode   <= 1'b1;
                  digit_cnt_r <= '0;
               end
`ifdef SMARTLOCK_AUTO_RELOCK_EN
               if (!relock_expired) relock_tmr <= relock_tmr - 1'b1;
`endif
            end
            S_PROG: begin
               if (clear_p) begin
                  state       <= S_OPEN;
                  out         <= 1'b1;
                  prog_mode   <= 1'b0;
                  digit_cnt_r <= '0;
               end else if (relock_expired) begin
                  state       <= S_ENTRY;
                  prog_mode   <= 1'b0;
                  digit_cnt_r <= '0;
               end else if (digit_evt) begin
                  if (!digit_ok || last_digit) begin
                     if (digit_ok) code_r <= shadow_nx;
                     state       <= S_OPEN;
                     out         <= 1'b1;
                     prog_mode   <= 1'b0;
                     digit_cnt_r <= '0;
                  end else begin
                     shadow_r    <= shadow_nx;
                     digit_cnt_r <= digit_cnt_r + 1'b1;
                  end
               end
`ifdef SMARTLOCK_AUTO_RELOCK_EN
               if (clear_p || digit_evt) relock_tmr <= RELOCK_LOAD;
               else if (!relock_expired) relock_tmr <= relock_tmr - 1'b1;
`endif
            end
            S_LOCKOUT: begin
               if (lock_tmr == '0) begin
                  state      <= S_ENTRY;
                  locked_out <= 1'b0;
                  fail_cnt_r <= '0;
               end else begin
                  lock_tmr <= lock_tmr - 1'b1;
               end
            end
            default: begin
               state       <= S_ENTRY;
               out         <= 1'b0;
               locked_out  <= 1'b0;
               prog_mode   <= 1'b0;
               digit_cnt_r <= '0;
               mismatch_r  <= 1'b0;
            end
         endcase
      end
   end

   assign digit_cnt = 4'(digit_cnt_r);
   assign fail_cnt  = 4'(fail_cnt_r);

endmodule
